// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, launches reads into the instruction ROM, tags them
// through the ROM pipeline and buffers returned words in a small FIFO towards decode.
module instr_fetch #(
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       ROM_LAT    = 2,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_cs,
    output logic              rom_oe,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);
    localparam int unsigned     PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CntW    = $clog2(FIFO_DEPTH + ROM_LAT + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_en_q, rom_en_d;
    logic              epoch_q, epoch_d;

    logic              tag_vld_q [ROM_LAT];
    logic              tag_vld_d [ROM_LAT];
    logic [ADDR_W-1:0] tag_pc_q  [ROM_LAT];
    logic [ADDR_W-1:0] tag_pc_d  [ROM_LAT];
    logic              tag_ep_q  [ROM_LAT];
    logic              tag_ep_d  [ROM_LAT];

    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d   [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [CntW-1:0]   inflight;
    logic              can_launch;
    logic              capture;
    logic              pop;

    // Credit check counts every tag still in the ROM pipeline, so the FIFO can never overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(ROM_LAT); i++) begin
            inflight = inflight + CntW'(tag_vld_q[i]);
        end
        can_launch = !halt && ((count_q + inflight) < CntW'(FIFO_DEPTH));
        capture    = tag_vld_q[ROM_LAT-1] && (tag_ep_q[ROM_LAT-1] == epoch_q) && !redirect_valid;
        pop        = (count_q != '0) && instr_ready;
    end

    always_comb begin
        pc_d        = pc_q;
        rom_addr_d  = rom_addr_q;
        rom_en_d    = 1'b0;
        epoch_d     = epoch_q;
        tag_vld_d   = tag_vld_q;
        tag_pc_d    = tag_pc_q;
        tag_ep_d    = tag_ep_q;
        tag_vld_d[0] = 1'b0;
        tag_pc_d[0]  = pc_q;
        tag_ep_d[0]  = epoch_q;

        if (redirect_valid) begin
            epoch_d = ~epoch_q;
            pc_d    = redirect_pc;
            if (can_launch) begin
                rom_addr_d   = redirect_pc;
                rom_en_d     = 1'b1;
                pc_d         = redirect_pc + ADDR_W'(1);
                tag_vld_d[0] = 1'b1;
                tag_pc_d[0]  = redirect_pc;
                tag_ep_d[0]  = ~epoch_q;
            end
        end else if (can_launch) begin
            rom_addr_d   = pc_q;
            rom_en_d     = 1'b1;
            pc_d         = pc_q + ADDR_W'(1);
            tag_vld_d[0] = 1'b1;
        end

        // Older tags are also invalidated on redirect so a 1-bit epoch cannot alias at ROM_LAT>2.
        for (int i = 1; i < int'(ROM_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1] && !redirect_valid;
            tag_pc_d[i]  = tag_pc_q[i-1];
            tag_ep_d[i]  = tag_ep_q[i-1];
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;

        if (redirect_valid) begin
            rptr_d  = wptr_q;
            count_d = '0;
        end else begin
            if (capture) begin
                fifo_data_d[wptr_q] = rom_data;
                fifo_pc_d[wptr_q]   = tag_pc_q[ROM_LAT-1];
                wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
            end
            count_d = count_q + CntW'(capture) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rom_addr_q <= RESET_PC;
            rom_en_q   <= 1'b0;
            epoch_q    <= 1'b0;
            for (int i = 0; i < int'(ROM_LAT); i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_pc_q[i]  <= '0;
                tag_ep_q[i]  <= 1'b0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q        <= pc_d;
            rom_addr_q  <= rom_addr_d;
            rom_en_q    <= rom_en_d;
            epoch_q     <= epoch_d;
            tag_vld_q   <= tag_vld_d;
            tag_pc_q    <= tag_pc_d;
            tag_ep_q    <= tag_ep_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_cs      = rom_en_q;
    assign rom_oe      = rom_en_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = fifo_data_q[rptr_q];
    assign instr_pc    = fifo_pc_q[rptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural ROM with two-edge read latency, directed scenarios and a
// randomized run checked against an in-order PC stream model.
module tb_instr_fetch;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ROM_LAT    = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [7:0]  RESET_PC   = 8'h00;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic        rom_cs;
    logic        rom_oe;
    logic [15:0] rom_data;
    logic        halt;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;

    logic [15:0] rom [256];
    logic [15:0] rom_stage;
    logic [7:0]  nxt_pc;
    int          total;
    int          bad;

    instr_fetch #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ROM_LAT    (ROM_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_cs         (rom_cs),
        .rom_oe         (rom_oe),
        .rom_data       (rom_data),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Address registered at edge N is read at N+1 and presented for sampling at N+2.
    always @(posedge clk) rom_stage <= (rom_cs && rom_oe) ? rom[rom_addr] : 16'hFFFF;
    assign rom_data = rom_stage;

    task automatic start(input logic rdy);
        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        instr_ready = rdy;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        instr_ready = 1'b0;
        #1;
        total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", rom_cs); end
        total++; if (rom_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", rom_oe); end
        total++; if (rom_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", rom_addr, RESET_PC); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", instr_data); end
        total++; if (instr_pc !== 8'h0) begin bad++; $display("FAIL reset_pc got=%h exp=00", instr_pc); end
    endtask

    task automatic test_first_fetch;
        logic       exp_v;
        logic [7:0] exp_pc;
        start(1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_v = (k >= 3);
            total++;
            if (instr_valid !== exp_v) begin
                bad++; $display("FAIL first_valid cycle=%0d got=%b exp=%b", k, instr_valid, exp_v);
            end
            if (k >= 3) begin
                exp_pc = 8'(k - 3);
                total++;
                if (instr_pc !== exp_pc || instr_data !== rom[exp_pc]) begin
                    bad++; $display("FAIL first_word cycle=%0d got=%h/%h exp=%h/%h", k, instr_pc,
                                    instr_data, exp_pc, rom[exp_pc]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int         launches;
        int         got;
        logic [7:0] exp_pc;
        start(1'b0);
        launches = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rom_cs) launches++;
            if (instr_valid) begin
                total++;
                if (instr_pc !== 8'h00 || instr_data !== 16'h1613) begin
                    bad++; $display("FAIL bp_head got=%h/%h exp=00/1613", instr_pc, instr_data);
                end
            end
        end
        total++; if (launches != int'(FIFO_DEPTH)) begin bad++; $display("FAIL bp_launches got=%0d exp=%0d", launches, FIFO_DEPTH); end
        total++; if (rom_oe !== 1'b0) begin bad++; $display("FAIL bp_oe got=%b exp=0", rom_oe); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", instr_valid); end
        instr_ready = 1'b1;
        exp_pc = 8'h00; got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== exp_pc || instr_data !== rom[exp_pc]) begin
                    bad++; $display("FAIL bp_order got=%h/%h exp=%h/%h", instr_pc, instr_data, exp_pc, rom[exp_pc]);
                end
                exp_pc++; got++;
            end
            @(negedge clk);
        end
        total++; if (got != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", got); end
    endtask

    task automatic test_redirect;
        int got;
        start(1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", instr_valid); end
        nxt_pc = 8'h40; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc >= 8'h01 && instr_pc <= 8'h03) begin
                    bad++; $display("FAIL redir_stale got=%h exp=not 01..03", instr_pc);
                end
                total++;
                if (instr_pc !== nxt_pc || instr_data !== rom[nxt_pc]) begin
                    bad++; $display("FAIL redir_seq got=%h/%h exp=%h/%h", instr_pc, instr_data, nxt_pc, rom[nxt_pc]);
                end
                nxt_pc++; got++;
            end
            @(negedge clk);
        end
        total++; if (got != 4) begin bad++; $display("FAIL redir_count got=%0d exp=4", got); end
    endtask

    task automatic test_wrap;
        int got;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        nxt_pc = 8'hFE; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== nxt_pc || instr_data !== rom[nxt_pc]) begin
                    bad++; $display("FAIL wrap_seq got=%h/%h exp=%h/%h", instr_pc, instr_data, nxt_pc, rom[nxt_pc]);
                end
                nxt_pc++; got++;
            end
            @(negedge clk);
        end
        total++; if (got != 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", got); end
    endtask

    task automatic test_halt;
        int got;
        halt = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== nxt_pc || instr_data !== rom[nxt_pc]) begin
                    bad++; $display("FAIL halt_inflight got=%h/%h exp=%h/%h", instr_pc, instr_data, nxt_pc, rom[nxt_pc]);
                end
                nxt_pc++;
            end
            @(negedge clk);
            total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL halt_cs got=%b exp=0", rom_cs); end
        end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_drain got=%b exp=0", instr_valid); end
        halt = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== nxt_pc || instr_data !== rom[nxt_pc]) begin
                    bad++; $display("FAIL halt_resume got=%h/%h exp=%h/%h", instr_pc, instr_data, nxt_pc, rom[nxt_pc]);
                end
                nxt_pc++; got++;
            end
            @(negedge clk);
        end
        total++; if (got != 4) begin bad++; $display("FAIL halt_count got=%0d exp=4", got); end
    endtask

    task automatic test_reset_mid;
        int got;
        start(1'b0);
        repeat (4) @(negedge clk);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", instr_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rom_cs !== 1'b0 || rom_oe !== 1'b0) begin bad++; $display("FAIL rmid_cs got=%b%b exp=00", rom_cs, rom_oe); end
        total++; if (rom_addr !== RESET_PC) begin bad++; $display("FAIL rmid_addr got=%h exp=%h", rom_addr, RESET_PC); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== 16'h0 || instr_pc !== 8'h0) begin bad++; $display("FAIL rmid_out got=%h/%h exp=00/0000", instr_pc, instr_data); end
        @(negedge clk);
        instr_ready = 1'b1; rst_n = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 1; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== RESET_PC || instr_data !== rom[RESET_PC]) begin
                    bad++; $display("FAIL rmid_first got=%h/%h exp=%h/%h", instr_pc, instr_data, RESET_PC, rom[RESET_PC]);
                end
                got++;
            end
        end
        total++; if (got != 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", got); end
    endtask

    task automatic test_random;
        logic       prev_halt;
        logic       prev_redir;
        logic [7:0] prev_tgt;
        int         got;
        start(1'b0);
        nxt_pc = RESET_PC;
        prev_halt = 1'b0; prev_redir = 1'b0; prev_tgt = 8'h00;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (prev_halt) begin
                total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL rand_halt_cs cycle=%0d got=%b exp=0", c, rom_cs); end
            end else if (prev_redir && rom_cs) begin
                total++; if (rom_addr !== prev_tgt) begin bad++; $display("FAIL rand_redir_addr got=%h exp=%h", rom_addr, prev_tgt); end
            end
            instr_ready    = ($urandom_range(0, 9) < 7);
            halt           = ($urandom_range(0, 9) < 2);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 8'($urandom);
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== nxt_pc || instr_data !== rom[nxt_pc]) begin
                    bad++; $display("FAIL rand_seq cycle=%0d got=%h/%h exp=%h/%h", c, instr_pc, instr_data, nxt_pc, rom[nxt_pc]);
                end
                nxt_pc++;
            end
            if (redirect_valid) nxt_pc = redirect_pc;
            prev_halt = halt; prev_redir = redirect_valid; prev_tgt = redirect_pc;
        end
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== nxt_pc || instr_data !== rom[nxt_pc]) begin
                    bad++; $display("FAIL rand_drain got=%h/%h exp=%h/%h", instr_pc, instr_data, nxt_pc, rom[nxt_pc]);
                end
                nxt_pc++; got++;
            end
        end
        total++; if (got != 4) begin bad++; $display("FAIL rand_drain_count got=%0d exp=4", got); end
    endtask

    initial begin
        total = 0; bad = 0; nxt_pc = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h1613; rom[1] = 16'h007F; rom[2] = 16'h007F; rom[3] = 16'h007F;
        test_reset;
        test_first_fetch;
        test_backpressure;
        test_redirect;
        test_wrap;
        test_halt;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
